// File: rtl/ppl_pkg.sv
// rtl/ppl_pkg.sv - shared widths and frame helpers for the ray pipeline pixel path
package ppl_pkg;

   localparam int PIX_AW = 20;
   localparam int TEX_AW = 13;
   localparam int TEX_W  = 16;

   function automatic int frame_last(input int h, input int v);
      return h * v - 1;
   endfunction

endpackage

// File: rtl/ppl_sfifo.sv
// rtl/ppl_sfifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module ppl_sfifo
   import ppl_pkg::*;
#(
   parameter int WIDTH = 36,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_FULL);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ppl_pixel_writer.sv
// rtl/ppl_pixel_writer.sv - texel fetch, pixel buffering and framebuffer write handshake
module ppl_pixel_writer
   import ppl_pkg::*;
#(
   parameter int H_DISP     = 1280,
   parameter int V_DISP     = 720,
   parameter int FIFO_DEPTH = 16,
   parameter int TEX_W      = ppl_pkg::TEX_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [PIX_AW-1:0]             in_pixel_addr,
   input  logic [TEX_AW-1:0]             in_texture_addr,
   output logic [TEX_AW-1:0]             tex_addr,
   input  logic [TEX_W-1:0]              tex_data,
   output logic                          fb_wr_req,
   output logic [PIX_AW-1:0]             fb_wr_addr,
   output logic [TEX_W-1:0]              fb_wr_data,
   input  logic                          fb_wr_ack,
   output logic                          frame_done,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int ENTRY_W = PIX_AW + TEX_W;
   localparam logic [PIX_AW:0]   FRAME_PIXELS = (PIX_AW+1)'(H_DISP * V_DISP);
   localparam logic [PIX_AW-1:0] LAST_ADDR    = PIX_AW'(frame_last(H_DISP, V_DISP));

   logic                s1_valid;
   logic [PIX_AW-1:0]   s1_addr;
   logic                push;
   logic                pop;
   logic                drop;
   logic                full;
   logic                empty;
   logic [ENTRY_W-1:0]  head;
   logic [PIX_AW-1:0]   head_addr;

   // ROM address goes straight out; the data lands one cycle later alongside s1_addr.
   assign tex_addr = in_texture_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
      end else begin
         s1_valid <= in_valid && ({1'b0, in_pixel_addr} < FRAME_PIXELS);
         s1_addr  <= in_pixel_addr;
      end
   end

   assign pop  = !empty && fb_wr_ack;
   assign push = s1_valid && (!full || pop);
   assign drop = s1_valid && !push;

   ppl_sfifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({s1_addr, tex_data}),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   // Head is gated so stale storage never shows on the bus when nothing is queued.
   assign head_addr  = head[ENTRY_W-1:TEX_W];
   assign fb_wr_req  = !empty;
   assign fb_wr_addr = empty ? '0 : head_addr;
   assign fb_wr_data = empty ? '0 : head[TEX_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && (head_addr == LAST_ADDR);
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ppl_pixel_writer.sv
// tb/tb_ppl_pixel_writer.sv - randomized and directed bench against a queue-based reference model
module tb_ppl_pixel_writer;

   localparam int FRAME = 1280 * 720;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [19:0] in_pixel_addr = '0;
   logic [12:0] in_texture_addr = '0;
   logic [12:0] tex_addr;
   logic [15:0] tex_data = '0;
   logic        fb_wr_req;
   logic [19:0] fb_wr_addr;
   logic [15:0] fb_wr_data;
   logic        fb_wr_ack = 1'b0;
   logic        frame_done;
   logic        overflow;
   logic        clr_overflow = 1'b0;
   logic [4:0]  fifo_level;

   int n_vec  = 0;
   int n_miss = 0;
   int fd_cnt = 0;

   logic [35:0] q[$];
   bit          m_s1_valid = 0;
   logic [19:0] m_s1_addr = '0;
   logic [12:0] m_s1_tex = '0;
   bit          m_ovf = 0;
   bit          m_fd = 0;

   ppl_pixel_writer #(
      .H_DISP(1280), .V_DISP(720), .FIFO_DEPTH(DEPTH), .TEX_W(16)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel_addr(in_pixel_addr),
      .in_texture_addr(in_texture_addr), .tex_addr(tex_addr), .tex_data(tex_data),
      .fb_wr_req(fb_wr_req), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
      .fb_wr_ack(fb_wr_ack), .frame_done(frame_done), .overflow(overflow),
      .clr_overflow(clr_overflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom(input logic [12:0] a);
      logic [31:0] t;
      if (a == 13'h0010) return 16'hABCD;
      t = {19'd0, a} * 32'h9E37;
      return t[15:0] ^ 16'h5A5A;
   endfunction

   always @(posedge clk) tex_data <= rom(tex_addr);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      bit req;
      req = (q.size() != 0);
      check_eq("req", 64'(fb_wr_req), 64'(req));
      check_eq("addr", 64'(fb_wr_addr), req ? 64'(q[0][35:16]) : 64'd0);
      check_eq("data", 64'(fb_wr_data), req ? 64'(q[0][15:0]) : 64'd0);
      check_eq("level", 64'(fifo_level), 64'(q.size()));
      check_eq("overflow", 64'(overflow), 64'(m_ovf));
      check_eq("frame_done", 64'(frame_done), 64'(m_fd));
      if (frame_done) fd_cnt++;
   endtask

   task automatic model_update(input bit v, input logic [19:0] pix, input logic [12:0] tex,
                               input bit ack, input bit clr);
      bit pop, push, drop;
      pop  = (q.size() > 0) && ack;
      m_fd = pop && (q[0][35:16] == 20'(FRAME - 1));
      push = m_s1_valid && ((q.size() < DEPTH) || pop);
      drop = m_s1_valid && !push;
      if (pop) void'(q.pop_front());
      if (push) q.push_back({m_s1_addr, rom(m_s1_tex)});
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_s1_valid = v && (int'(pix) < FRAME);
      m_s1_addr  = pix;
      m_s1_tex   = tex;
   endtask

   task automatic step(input bit v, input logic [19:0] pix, input logic [12:0] tex,
                       input bit ack, input bit clr);
      @(negedge clk);
      check_model();
      in_valid = v; in_pixel_addr = pix; in_texture_addr = tex;
      fb_wr_ack = ack; clr_overflow = clr;
      @(posedge clk);
      model_update(v, pix, tex, ack, clr);
   endtask

   task automatic idle(input int n, input bit ack);
      for (int i = 0; i < n; i++) step(0, '0, '0, ack, 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_req"}, 64'(fb_wr_req), 64'd0);
      check_eq({tag, "_addr"}, 64'(fb_wr_addr), 64'd0);
      check_eq({tag, "_data"}, 64'(fb_wr_data), 64'd0);
      check_eq({tag, "_level"}, 64'(fifo_level), 64'd0);
      check_eq({tag, "_ovf"}, 64'(overflow), 64'd0);
      check_eq({tag, "_fd"}, 64'(frame_done), 64'd0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      in_valid = 0; fb_wr_ack = 0; clr_overflow = 0;
      #2 rst = 1'b0;
      #1 check_zero_outputs("async_rst");
      q.delete();
      m_s1_valid = 0; m_ovf = 0; m_fd = 0;
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      bit v, ack, clr;
      logic [19:0] pix;
      int ack_pct;

      repeat (2) @(posedge clk);
      #1 check_zero_outputs("reset");
      check_eq("tex_addr_follow", 64'(tex_addr), 64'(in_texture_addr));
      #1 rst = 1'b1;

      // single beat, two-cycle latency
      step(1, 20'h00005, 13'h0010, 1, 0);
      idle(4, 1);

      // backpressure: 20 beats with ack low
      for (int i = 0; i < 20; i++) step(1, 20'(100 + i), 13'(i), 0, 0);
      idle(3, 0);
      #1 check_eq("bp_level", 64'(fifo_level), 64'd16);
      check_eq("bp_overflow", 64'(overflow), 64'd1);
      idle(20, 1);
      step(0, '0, '0, 1, 1);

      // full with simultaneous pop
      for (int i = 0; i < 16; i++) step(1, 20'(200 + i), 13'(i), 0, 0);
      idle(1, 0);
      step(1, 20'd300, 13'd7, 0, 0);
      step(0, '0, '0, 1, 0);
      #1 check_eq("fullpop_level", 64'(fifo_level), 64'd16);
      check_eq("fullpop_ovf", 64'(overflow), 64'd0);
      idle(18, 1);

      // frame end and out-of-range beat
      fd_cnt = 0;
      step(1, 20'(FRAME - 2), 13'd1, 1, 0);
      step(1, 20'(FRAME - 1), 13'd2, 1, 0);
      step(1, 20'(FRAME), 13'd3, 1, 0);
      idle(6, 1);
      check_eq("frame_pulses", 64'(fd_cnt), 64'd1);
      check_eq("oor_no_ovf", 64'(overflow), 64'd0);

      // drop and clear coincide, then clear alone
      for (int i = 0; i < 16; i++) step(1, 20'(400 + i), 13'(i), 0, 0);
      idle(1, 0);
      step(1, 20'd500, 13'd9, 0, 0);
      step(0, '0, '0, 0, 1);
      #1 check_eq("set_wins", 64'(overflow), 64'd1);
      step(0, '0, '0, 0, 1);
      #1 check_eq("clr_alone", 64'(overflow), 64'd0);
      idle(18, 1);

      // async reset with entries queued
      for (int i = 0; i < 5; i++) step(1, 20'(600 + i), 13'(i), 0, 0);
      step(1, 20'd700, 13'd5, 0, 0);
      @(negedge clk);
      check_eq("pre_rst_req", 64'(fb_wr_req), 64'd1);
      apply_reset();
      idle(5, 1);
      step(1, 20'd42, 13'h0010, 1, 0);
      idle(4, 1);

      // randomized traffic
      ack_pct = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) ack_pct = int'($urandom_range(10, 100));
         v = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) pix = 20'($urandom_range(FRAME - 4, FRAME + 4));
         else pix = 20'($urandom_range(0, 20'hFFFFF));
         ack = (int'($urandom_range(1, 100)) <= ack_pct);
         clr = ($urandom_range(0, 31) == 0);
         step(v, pix, 13'($urandom_range(0, 8191)), ack, clr);
      end
      idle(20, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
